// File: rtl/display_decoder.sv
// display_decoder
// Receiver-side inverse of the coding display path. On a rising edge of
// ready it captures a tens/units pair of 7-segment patterns, converts them
// back to a value 0..15 and maps that value through the inverse coding
// permutation to recover the original 4-bit word.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-low reset
//   dse      tens digit segments, bit6=a .. bit0=g
//   dsd      units digit segments, same order
//   ready    capture request (level); each rising edge starts one decode
//   a..d     recovered word, a = MSB
//   valid    one-cycle pulse when a decode completes
//   erro     qualifies valid: 1 = last decode was invalid
//   busy     high whenever the FSM is not idle
//   n_words  error-free decode count (wraps)
//   n_erros  failed decode count (saturates)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a ready rising edge; captures dse/dsd on trigger
// S_LATCH  | segment patterns looked up into digit values + pattern error
// S_DECODE | value range-checked and inverse permutation registered
// S_OUT    | result published on the following cycle with valid=1

module display_decoder #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_AS_ZERO  = 1'b1,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       dse,
    input  logic [6:0]       dsd,
    input  logic             ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             valid,
    output logic             erro,
    output logic             busy,
    output logic [CNT_W-1:0] n_words,
    output logic [CNT_W-1:0] n_erros
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_DECODE = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t state;
    state_t state_nx;

    logic             ready_q;
    logic             trigger;
    logic [6:0]       dse_r;
    logic [6:0]       dsd_r;
    logic [3:0]       dig_l;
    logic [3:0]       dig_r;
    logic             pat_err;
    logic [3:0]       word_r;
    logic             err_r;
    logic [3:0]       word_q;

    logic             do_capture;
    logic             do_latch;
    logic             do_decode;
    logic             do_out;

    logic [6:0]       dse_n;
    logic [6:0]       dsd_n;
    logic [4:0]       l_lk;
    logic [4:0]       r_lk;
    logic             l_blank_ok;
    logic [4:0]       v_sum;
    logic             range_err;

    // Returns {bad, digit}; patterns are in the active-low abcdefg form.
    function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
        case (seg)
            7'b0000001: return 5'd0;
            7'b1001111: return 5'd1;
            7'b0010010: return 5'd2;
            7'b0000110: return 5'd3;
            7'b1001100: return 5'd4;
            7'b0100100: return 5'd5;
            7'b0100000: return 5'd6;
            7'b0001111: return 5'd7;
            7'b0000000: return 5'd8;
            7'b0000100: return 5'd9;
            default:    return 5'b1_0000;
        endcase
    endfunction

    function automatic logic [3:0] inv_perm(input logic [3:0] v);
        case (v)
            4'd0:    return 4'd3;
            4'd1:    return 4'd13;
            4'd2:    return 4'd6;
            4'd3:    return 4'd1;
            4'd4:    return 4'd11;
            4'd5:    return 4'd15;
            4'd6:    return 4'd14;
            4'd7:    return 4'd12;
            4'd8:    return 4'd4;
            4'd9:    return 4'd2;
            4'd10:   return 4'd0;
            4'd11:   return 4'd10;
            4'd12:   return 4'd9;
            4'd13:   return 4'd7;
            4'd14:   return 4'd8;
            default: return 4'd5;
        endcase
    endfunction

    assign trigger = ready & ~ready_q;

    // Normalise to active-low so one lookup table serves both polarities.
    assign dse_n      = SEG_ACTIVE_LOW ? dse_r : ~dse_r;
    assign dsd_n      = SEG_ACTIVE_LOW ? dsd_r : ~dsd_r;
    assign l_lk       = seg_to_digit(dse_n);
    assign r_lk       = seg_to_digit(dsd_n);
    assign l_blank_ok = BLANK_AS_ZERO && (dse_n == SEG_BLANK);

    // Only the low bit of the tens digit contributes; any tens digit above 1
    // is caught by range_err, so the truncated sum is never used then.
    assign v_sum     = {1'b0, dig_r} + (dig_l[0] ? 5'd10 : 5'd0);
    assign range_err = (dig_l > 4'd1) || (v_sum > 5'd15);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (trigger) state_nx = S_LATCH;
            S_LATCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_OUT;
            S_OUT:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        do_capture = (state == S_IDLE) && trigger;
        do_latch   = (state == S_LATCH);
        do_decode  = (state == S_DECODE);
        do_out     = (state == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_q <= 1'b0;
            dse_r   <= '0;
            dsd_r   <= '0;
            dig_l   <= '0;
            dig_r   <= '0;
            pat_err <= 1'b0;
            word_r  <= '0;
            err_r   <= 1'b0;
            word_q  <= '0;
            valid   <= 1'b0;
            erro    <= 1'b0;
            n_words <= '0;
            n_erros <= '0;
        end else begin
            ready_q <= ready;
            valid   <= 1'b0;
            if (do_capture) begin
                dse_r <= dse;
                dsd_r <= dsd;
            end
            if (do_latch) begin
                dig_l   <= l_blank_ok ? 4'd0 : l_lk[3:0];
                dig_r   <= r_lk[3:0];
                pat_err <= r_lk[4] | (l_lk[4] & ~l_blank_ok);
            end
            if (do_decode) begin
                word_r <= inv_perm(v_sum[3:0]);
                err_r  <= pat_err | range_err;
            end
            if (do_out) begin
                valid <= 1'b1;
                erro  <= err_r;
                if (!err_r) begin
                    word_q  <= word_r;
                    n_words <= n_words + 1'b1;
                end else if (n_erros != {CNT_W{1'b1}}) begin
                    n_erros <= n_erros + 1'b1;
                end
            end
        end
    end

    assign {a, b, c, d} = word_q;

endmodule
